psram_line_prefetch: RTL and testbench

- Read-only prefetch stage directly upstream of the PSRAM controller.
- On each line start it issues sequential 16-bit word reads from a base address, up to WORDS_PER_LINE words, through the controller's stb/busy/done handshake.
- Returned words are buffered in a FIFO that the video/canvas pipeline pops one word at a time.

---
 rtl/psram_line_prefetch.sv | 174 +++++++++++++++++
 tb/tb_psram_line_prefetch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_line_prefetch.sv
// psram_line_prefetch: read-only line prefetcher in front of the PSRAM controller.
// Issues one sequential 16-bit read at a time through the stb/busy/done handshake
// and buffers returned words in a small FIFO for the pixel pipeline.
// Optional macro PREFETCH_HOLD_LAST_EN: an empty pop repeats the last word instead of 0.
module psram_line_prefetch #(
    parameter int unsigned WORDS_PER_LINE = 320,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned ADDR_STEP      = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_line_start,
    input  logic [23:0]                   i_line_base,
    input  logic                          i_pop,
    output logic [15:0]                   o_data,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_level,
    output logic                          o_underflow,
    output logic                          o_line_done,
    output logic                          o_stb,
    output logic                          o_we,
    output logic [23:0]                   o_addr,
    output logic [15:0]                   o_din,
    input  logic                          i_busy,
    input  logic                          i_done,
    input  logic [15:0]                   i_dout
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [15:0]      WPL16    = 16'(WORDS_PER_LINE);
    localparam logic [23:0]      STEP24   = 24'(ADDR_STEP);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT} state_t;

    state_t             state_q, state_d;
    logic [23:0]        cur_addr_q, cur_addr_d;
    logic [15:0]        left_q, left_d;
    logic               abort_q, abort_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [15:0]        data_q, data_d;
    logic               uf_q, uf_d;
    logic               wr_en, pop_ok, rdy;
    logic [15:0]        mem [FIFO_DEPTH];

    // Controller idle also covers its power-up init, during which busy is held.
    assign rdy = !i_busy && i_done;

    // Request sequencing: one outstanding read; a line start marks the in-flight read as discarded.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        left_d     = left_q;
        abort_d    = abort_q;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_line_start && left_q != '0 && level_q < FULL_LVL && rdy)
                    state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
                abort_d = i_line_start;
            end
            WAIT_BUSY: begin
                // busy may not have risen yet, so the abort is remembered until it does;
                // otherwise the stale done of the previous access would end ABORT early
                if (i_line_start)
                    abort_d = 1'b1;
                if (i_busy)
                    state_d = (abort_q || i_line_start) ? ABORT : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (rdy) begin
                    state_d = IDLE;
                    if (!i_line_start) begin
                        wr_en      = 1'b1;
                        cur_addr_d = cur_addr_q + STEP24;
                        left_d     = left_q - 1'b1;
                    end
                end else if (i_line_start) begin
                    state_d = ABORT;
                end
            end
            ABORT: begin
                if (rdy)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_line_start) begin
            cur_addr_d = i_line_base;
            left_d     = WPL16;
        end
    end

    // FIFO bookkeeping and registered pop output; line start flushes and beats a pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        data_d   = data_q;
        uf_d     = uf_q;
        pop_ok   = i_pop && !i_line_start && (level_q != '0);
        if (i_line_start) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            uf_d     = 1'b0;
        end else begin
            if (wr_en)
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                data_d   = mem[rd_ptr_q];
            end else if (i_pop) begin
                uf_d = 1'b1;
`ifdef PREFETCH_HOLD_LAST_EN
                data_d = data_q;
`else
                data_d = 16'h0000;
`endif
            end
            if (wr_en && !pop_ok)
                level_d = level_q + 1'b1;
            else if (!wr_en && pop_ok)
                level_d = level_q - 1'b1;
        end
    end

    // State and control registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            left_q     <= '0;
            abort_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            data_q     <= '0;
            uf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            left_q     <= left_d;
            abort_q    <= abort_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            data_q     <= data_d;
            uf_q       <= uf_d;
        end
    end

    // Word storage; contents need no reset since level gates every read.
    always_ff @(posedge i_clk) begin
        if (wr_en)
            mem[wr_ptr_q] <= i_dout;
    end

    assign o_stb       = (state_q == ISSUE);
    assign o_addr      = cur_addr_q;
    assign o_we        = 1'b0;
    assign o_din       = 16'h0000;
    assign o_data      = data_q;
    assign o_empty     = (level_q == '0);
    assign o_level     = level_q;
    assign o_underflow = uf_q;
    assign o_line_done = (left_q == '0) && (state_q != ABORT);

endmodule

// File: tb/tb_psram_line_prefetch.sv
// Bench for psram_line_prefetch: two instances (4-word and 40-word lines), each with
// a 12-cycle read controller model returning addr[15:0]. Expected request addresses
// and popped words are queued when a line is started and consumed as the DUT produces them.
module tb_psram_line_prefetch;

    localparam int LAT = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ls_a = 1'b0, ls_b = 1'b0, pop_a = 1'b0, pop_b = 1'b0;
    logic [23:0] base_a = '0, base_b = '0;
    logic [15:0] data_a, data_b, din_a, din_b;
    logic        empty_a, empty_b, uf_a, uf_b, done_a, done_b;
    logic        stb_a, stb_b, we_a, we_b;
    logic [4:0]  lvl_a, lvl_b;
    logic [23:0] addr_a, addr_b;

    // controller models, index 0 -> DUT a, 1 -> DUT b; start in power-up init (busy)
    logic [1:0]  c_busy = 2'b11;
    logic [1:0]  c_done = 2'b00;
    logic [15:0] c_dout [2] = '{16'h0, 16'h0};
    logic [23:0] c_addr [2] = '{24'h0, 24'h0};
    int          c_cnt  [2] = '{8, 8};
    logic [1:0]  m_stb;
    logic [23:0] m_addr [2];
    assign m_stb     = {stb_b, stb_a};
    assign m_addr[0] = addr_a;
    assign m_addr[1] = addr_b;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (c_cnt[c] > 0) begin
                c_cnt[c] <= c_cnt[c] - 1;
                if (c_cnt[c] == 1) begin
                    c_busy[c] <= 1'b0;
                    c_done[c] <= 1'b1;
                    c_dout[c] <= c_addr[c][15:0];
                end
            end else if (m_stb[c]) begin
                c_busy[c] <= 1'b1;
                c_done[c] <= 1'b0;
                c_cnt[c]  <= LAT;
                c_addr[c] <= m_addr[c];
            end
        end
    end

    psram_line_prefetch #(.WORDS_PER_LINE(4), .FIFO_DEPTH(16), .ADDR_STEP(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_line_start(ls_a), .i_line_base(base_a), .i_pop(pop_a),
        .o_data(data_a), .o_empty(empty_a), .o_level(lvl_a), .o_underflow(uf_a),
        .o_line_done(done_a), .o_stb(stb_a), .o_we(we_a), .o_addr(addr_a), .o_din(din_a),
        .i_busy(c_busy[0]), .i_done(c_done[0]), .i_dout(c_dout[0]));

    psram_line_prefetch #(.WORDS_PER_LINE(40), .FIFO_DEPTH(16), .ADDR_STEP(1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_line_start(ls_b), .i_line_base(base_b), .i_pop(pop_b),
        .o_data(data_b), .o_empty(empty_b), .o_level(lvl_b), .o_underflow(uf_b),
        .o_line_done(done_b), .o_stb(stb_b), .o_we(we_b), .o_addr(addr_b), .o_din(din_b),
        .i_busy(c_busy[1]), .i_done(c_done[1]), .i_dout(c_dout[1]));

    int n_checks = 0;
    int n_fail   = 0;
    int stb_cnt_a = 0, stb_cnt_b = 0;
    logic prev_stb_a = 1'b0, prev_stb_b = 1'b0;
    logic [23:0] exp_addr_a [$];
    logic [23:0] exp_addr_b [$];
    logic [15:0] exp_data_a [$];
    logic [15:0] exp_data_b [$];

    // one clock; sample 1 time unit after the edge and score every request strobe
    task automatic tick();
        logic [23:0] ea;
        @(posedge clk);
        #1;
        if (stb_a) begin
            stb_cnt_a++;
            n_checks++;
            if (prev_stb_a) begin n_fail++; $display("FAIL stb_width_a: o_stb high two cycles in a row, required one"); end
            n_checks++;
            if (c_busy[0] || !c_done[0]) begin n_fail++; $display("FAIL stb_not_ready_a: busy=%0b done=%0b at strobe, required busy=0 done=1", c_busy[0], c_done[0]); end
            n_checks++;
            if (exp_addr_a.size() == 0) begin
                n_fail++; $display("FAIL stb_unexpected_a: strobe addr=%06h with no request expected", addr_a);
            end else begin
                ea = exp_addr_a.pop_front();
                if (addr_a !== ea) begin n_fail++; $display("FAIL stb_addr_a: got %06h, required %06h", addr_a, ea); end
            end
        end
        if (stb_b) begin
            stb_cnt_b++;
            n_checks++;
            if (prev_stb_b) begin n_fail++; $display("FAIL stb_width_b: o_stb high two cycles in a row, required one"); end
            n_checks++;
            if (exp_addr_b.size() == 0) begin
                n_fail++; $display("FAIL stb_unexpected_b: strobe addr=%06h with no request expected", addr_b);
            end else begin
                ea = exp_addr_b.pop_front();
                if (addr_b !== ea) begin n_fail++; $display("FAIL stb_addr_b: got %06h, required %06h", addr_b, ea); end
            end
        end
        prev_stb_a = stb_a;
        prev_stb_b = stb_b;
    endtask

    task automatic start_line_a(input logic [23:0] base, input logic with_pop);
        exp_addr_a.delete();
        exp_data_a.delete();
        for (int i = 0; i < 4; i++) begin
            exp_addr_a.push_back(base + 24'(i));
            exp_data_a.push_back(16'(base + 24'(i)));
        end
        stb_cnt_a = 0;
        base_a = base; ls_a = 1'b1; pop_a = with_pop;
        tick();
        ls_a = 1'b0; pop_a = 1'b0;
    endtask

    task automatic start_line_b(input logic [23:0] base);
        exp_addr_b.delete();
        exp_data_b.delete();
        for (int i = 0; i < 40; i++) begin
            exp_addr_b.push_back(base + 24'(i));
            exp_data_b.push_back(16'(base + 24'(i)));
        end
        stb_cnt_b = 0;
        base_b = base; ls_b = 1'b1;
        tick();
        ls_b = 1'b0;
    endtask

    task automatic do_pop_a();
        pop_a = 1'b1; tick(); pop_a = 1'b0;
    endtask

    task automatic wait_full_line_a();
        for (int i = 0; i < 400; i++) begin
            if (done_a && lvl_a == 5'd4) break;
            tick();
        end
        n_checks++;
        if (!(done_a && lvl_a == 5'd4)) begin n_fail++; $display("FAIL line_fill_a: done=%0b level=%0d, required done=1 level=4", done_a, lvl_a); end
    endtask

    task automatic pop_all_a(input string tag);
        logic [15:0] ed;
        for (int i = 0; i < 4; i++) begin
            ed = exp_data_a.pop_front();
            do_pop_a();
            n_checks++;
            if (data_a !== ed) begin n_fail++; $display("FAIL %s_pop%0d: data=%04h, required %04h", tag, i, data_a, ed); end
        end
        n_checks++;
        if (!empty_a || lvl_a !== 5'd0) begin n_fail++; $display("FAIL %s_drained: empty=%0b level=%0d, required 1/0", tag, empty_a, lvl_a); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (stb_a !== 1'b0 || addr_a !== 24'h0 || data_a !== 16'h0 || empty_a !== 1'b1 ||
            lvl_a !== 5'd0 || uf_a !== 1'b0 || done_a !== 1'b1 || we_a !== 1'b0 || din_a !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_a: stb=%0b addr=%06h data=%04h empty=%0b lvl=%0d uf=%0b done=%0b we=%0b din=%04h, required 0/0/0/1/0/0/1/0/0",
                     stb_a, addr_a, data_a, empty_a, lvl_a, uf_a, done_a, we_a, din_a);
        end
        n_checks++;
        if (stb_b !== 1'b0 || addr_b !== 24'h0 || data_b !== 16'h0 || empty_b !== 1'b1 ||
            lvl_b !== 5'd0 || uf_b !== 1'b0 || done_b !== 1'b1 || we_b !== 1'b0 || din_b !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_b: stb=%0b addr=%06h data=%04h empty=%0b lvl=%0d uf=%0b done=%0b we=%0b din=%04h, required 0/0/0/1/0/0/1/0/0",
                     stb_b, addr_b, data_b, empty_b, lvl_b, uf_b, done_b, we_b, din_b);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_fetch();
        start_line_a(24'h000100, 1'b0);
        n_checks++;
        if (done_a !== 1'b0) begin n_fail++; $display("FAIL basic_done_clear: line_done=%0b, required 0", done_a); end
        wait_full_line_a();
        n_checks++;
        if (stb_cnt_a != 4) begin n_fail++; $display("FAIL basic_stb_count: %0d strobes, required 4", stb_cnt_a); end
        pop_all_a("basic");
    endtask

    task automatic test_backpressure();
        logic [15:0] ed;
        start_line_b(24'h002000);
        for (int i = 0; i < 800; i++) begin
            if (lvl_b == 5'd16) break;
            tick();
        end
        repeat (60) tick();
        n_checks++;
        if (lvl_b !== 5'd16 || stb_cnt_b != 16) begin n_fail++; $display("FAIL bp_stop: level=%0d strobes=%0d, required 16/16", lvl_b, stb_cnt_b); end
        ed = exp_data_b.pop_front();
        pop_b = 1'b1; tick(); pop_b = 1'b0;
        n_checks++;
        if (data_b !== ed || lvl_b !== 5'd15) begin n_fail++; $display("FAIL bp_pop: data=%04h level=%0d, required %04h/15", data_b, lvl_b, ed); end
        repeat (60) tick();
        n_checks++;
        if (lvl_b !== 5'd16 || stb_cnt_b != 17) begin n_fail++; $display("FAIL bp_refill: level=%0d strobes=%0d, required 16/17", lvl_b, stb_cnt_b); end
    endtask

    task automatic test_line_start_mid();
        start_line_a(24'h000500, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (stb_cnt_a >= 1) break;
            tick();
        end
        do_pop_a();
        n_checks++;
        if (uf_a !== 1'b1) begin n_fail++; $display("FAIL mid_uf_set: underflow=%0b, required 1", uf_a); end
        tick(); tick();
        // read of 000500 is still in flight; start a new line and pop in the same cycle
        start_line_a(24'h000800, 1'b1);
        n_checks++;
        if (lvl_a !== 5'd0 || uf_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL mid_flush: level=%0d underflow=%0b done=%0b, required 0/0/0", lvl_a, uf_a, done_a);
        end
        wait_full_line_a();
        pop_all_a("mid");
    endtask

    task automatic test_underflow();
        logic [15:0] ed;
        start_line_a(24'h00BEEC, 1'b0);
        wait_full_line_a();
        pop_all_a("uf");
`ifdef PREFETCH_HOLD_LAST_EN
        ed = 16'hBEEF;
`else
        ed = 16'h0000;
`endif
        do_pop_a();
        n_checks++;
        if (uf_a !== 1'b1 || data_a !== ed || lvl_a !== 5'd0) begin
            n_fail++; $display("FAIL uf_empty_pop: underflow=%0b data=%04h level=%0d, required 1/%04h/0", uf_a, data_a, ed, lvl_a);
        end
    endtask

    task automatic test_wrap_simul();
        logic [15:0] ed;
        int target;
        start_line_a(24'hFFFFFE, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (lvl_a == 5'd1) break;
            tick();
        end
        target = stb_cnt_a + 1;
        for (int i = 0; i < 100; i++) begin
            if (stb_cnt_a >= target) break;
            tick();
        end
        tick();
        for (int i = 0; i < 100; i++) begin
            if (!c_busy[0]) break;
            tick();
        end
        // controller has just finished: the DUT writes on the next edge, pop alongside it
        ed = exp_data_a.pop_front();
        do_pop_a();
        n_checks++;
        if (lvl_a !== 5'd1 || data_a !== ed) begin n_fail++; $display("FAIL simul_pop_write: level=%0d data=%04h, required 1/%04h", lvl_a, data_a, ed); end
        for (int i = 0; i < 400; i++) begin
            if (done_a && lvl_a == 5'd3) break;
            tick();
        end
        n_checks++;
        if (stb_cnt_a != 4 || lvl_a !== 5'd3) begin n_fail++; $display("FAIL wrap_count: strobes=%0d level=%0d, required 4/3", stb_cnt_a, lvl_a); end
        for (int i = 0; i < 3; i++) begin
            ed = exp_data_a.pop_front();
            do_pop_a();
            n_checks++;
            if (data_a !== ed) begin n_fail++; $display("FAIL wrap_pop%0d: data=%04h, required %04h", i, data_a, ed); end
        end
    endtask

    task automatic test_reset_mid();
        start_line_a(24'h000300, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (stb_cnt_a >= 1) break;
            tick();
        end
        repeat (6) tick();
        exp_addr_a.delete();
        exp_data_a.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (stb_a !== 1'b0 || addr_a !== 24'h0 || data_a !== 16'h0 || empty_a !== 1'b1 ||
            lvl_a !== 5'd0 || uf_a !== 1'b0 || done_a !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_values: stb=%0b addr=%06h data=%04h empty=%0b lvl=%0d uf=%0b done=%0b, required 0/0/0/1/0/0/1",
                               stb_a, addr_a, data_a, empty_a, lvl_a, uf_a, done_a);
        end
        n_checks++;
        if (c_busy[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: controller busy=%0b after reset, required 1", c_busy[0]); end
        start_line_a(24'h000900, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (stb_cnt_a >= 1) break;
            tick();
        end
        n_checks++;
        if (stb_cnt_a < 1) begin n_fail++; $display("FAIL rstmid_resume: %0d strobes after reset, required at least 1", stb_cnt_a); end
        wait_full_line_a();
        pop_all_a("rstmid");
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_backpressure();
        test_line_start_mid();
        test_underflow();
        test_wrap_simul();
        test_reset_mid();
        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
